// File: rtl/universal_shift_reg.sv
// rtl/universal_shift_reg.sv - parametrised universal shift register with counted burst-shift engine
//
// Purpose:
//   WIDTH-bit register supporting hold, shift left/right, parallel load,
//   rotate left/right and (optionally) arithmetic right shift, plus a burst
//   engine that performs burst_len serial shifts autonomously after a start.
//
// Optional feature macro: SHIFT_ARITH_EN
//   defined   -> mode 3'b101 is an arithmetic right shift
//   undefined -> mode 3'b101 holds, no sign-replication logic
//
// Ports:
//   clk        in  1        rising-edge clock
//   reset      in  1        synchronous, active-high
//   mode       in  3        operation select (idle and start=0 only)
//   sin_l      in  1        serial input into q[0] on left shifts
//   sin_r      in  1        serial input into q[WIDTH-1] on right shifts
//   par_in     in  WIDTH    parallel load data
//   start      in  1        burst request, sampled only when idle
//   burst_len  in  BURST_W  number of burst shifts, captured with start
//   burst_dir  in  1        burst direction: 0 = left, 1 = right
//   q          out WIDTH    register contents
//   sout_msb   out 1        q[WIDTH-1]
//   sout_lsb   out 1        q[0]
//   busy       out 1        burst in progress
//   done       out 1        one-cycle burst-complete pulse

module universal_shift_reg #(
  parameter int WIDTH   = 8,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         mode,
  input  logic               sin_l,
  input  logic               sin_r,
  input  logic [WIDTH-1:0]   par_in,
  input  logic               start,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               burst_dir,
  output logic [WIDTH-1:0]   q,
  output logic               sout_msb,
  output logic               sout_lsb,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               done_q, done_d;

  // Single-step shift results shared by mode operations and the burst engine.
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] mode_val;

  assign shl_val = {data_q[WIDTH-2:0], sin_l};
  assign shr_val = {sin_r, data_q[WIDTH-1:1]};

  always_comb begin
    mode_val = data_q;
    case (mode)
      3'b001:  mode_val = shl_val;
      3'b010:  mode_val = shr_val;
      3'b011:  mode_val = par_in;
      3'b100:  mode_val = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`ifdef SHIFT_ARITH_EN
      3'b101:  mode_val = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
`else
      3'b101:  mode_val = data_q;
`endif
      3'b110:  mode_val = {data_q[0], data_q[WIDTH-1:1]};
      default: mode_val = data_q;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A zero-length burst completes immediately without touching q.
          if (burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_BURST;
            cnt_d   = burst_len;
            dir_d   = burst_dir;
          end
        end else begin
          data_d = mode_val;
        end
      end
      ST_BURST: begin
        data_d = dir_q ? shr_val : shl_val;
        cnt_d  = cnt_q - 1'b1;
        // cnt_q == 1 means this edge performs the final shift.
        if (cnt_q == {{(BURST_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    q        = data_q;
    sout_msb = data_q[WIDTH-1];
    sout_lsb = data_q[0];
    busy     = (state_q == ST_BURST);
    done     = done_q;
  end

endmodule
